// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            requesters, with registered operands and a held response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_zero,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic                r_last_grant_q, w_last_grant_d;
    logic                r_gid_q, w_gid_d;
    logic [OP_W-1:0]     r_op_q, w_op_d;
    logic [DATA_W-1:0]   r_a_q, w_a_d;
    logic [DATA_W-1:0]   r_b_q, w_b_d;
    logic [DATA_W-1:0]   r_data_q, w_data_d;
    logic                r_zero_q, w_zero_d;

    logic [1:0]          w_sel;
    logic                w_win;

    // Both valid: the requester that did not win last time goes next.
    always_comb begin
        w_sel = 2'b00;
        case (req_valid)
            2'b01:   w_sel = 2'b01;
            2'b10:   w_sel = 2'b10;
            2'b11:   w_sel = r_last_grant_q ? 2'b01 : 2'b10;
            default: w_sel = 2'b00;
        endcase
    end

    assign w_win = w_sel[1];

    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_gid_d        = r_gid_q;
        w_op_d         = r_op_q;
        w_a_d          = r_a_q;
        w_b_d          = r_b_q;
        w_data_d       = r_data_q;
        w_zero_d       = r_zero_q;
        req_ready      = 2'b00;
        resp_valid     = 2'b00;

        case (r_state_q)
            ST_IDLE: begin
                req_ready = w_sel & {2{reset_n}};
                if (|(req_valid & req_ready)) begin
                    w_op_d         = w_win ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
                    w_a_d          = w_win ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
                    w_b_d          = w_win ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
                    w_gid_d        = w_win;
                    w_last_grant_d = w_win;
                    w_state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_data_d  = alu_result;
                w_zero_d  = alu_zero;
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = r_gid_q ? 2'b10 : 2'b01;
                if (resp_ready[r_gid_q]) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q      <= ST_IDLE;
            r_last_grant_q <= 1'b1;
            r_gid_q        <= 1'b0;
            r_op_q         <= '0;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_data_q       <= '0;
            r_zero_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_gid_q        <= w_gid_d;
            r_op_q         <= w_op_d;
            r_a_q          <= w_a_d;
            r_b_q          <= w_b_d;
            r_data_q       <= w_data_d;
            r_zero_q       <= w_zero_d;
        end
    end

    assign alu_op    = r_op_q;
    assign alu_a     = r_a_q;
    assign alu_b     = r_b_q;
    assign resp_data = r_data_q;
    assign resp_zero = r_zero_q;
    assign busy      = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire
